down_counter_tc: RTL and testbench

Loadable, parameterized synchronous down counter with a registered terminal-count pulse, one-shot or auto-reload operation. It counts in the opposite direction to the team's 2-bit synchronous up counter and serves as the timeout/interval timer beside it. A load value arms the counter. It decrements once per enabled clock to zero and then either stops or reloads.

---
 rtl/counter_pkg.sv | 13 +
 rtl/down_counter_tc_if.sv | 32 +++
 rtl/down_counter_tc.sv | 62 ++++++
 tb/tb_down_counter_tc.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: FSM state encoding and the
// mode constants used to select one-shot or periodic operation.
package counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned ONE_SHOT = 0;
  localparam int unsigned PERIODIC = 1;

endpackage

// File: rtl/down_counter_tc_if.sv
// Control/status bundle for down_counter_tc. The master drives load/enable
// and observes count, terminal count and busy; the slave is the counter.
interface down_counter_tc_if #(
  parameter int unsigned WIDTH = 2
) ();

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] count_out;
  logic             tc;
  logic             busy;

  modport master (
    output load,
    output load_val,
    output en,
    input  count_out,
    input  tc,
    input  busy
  );

  modport slave (
    input  load,
    input  load_val,
    input  en,
    output count_out,
    output tc,
    output busy
  );

endinterface

// File: rtl/down_counter_tc.sv
// Loadable down counter with registered terminal-count pulse. Counts down
// once per enabled clock to zero, then stops (one-shot) or reloads the last
// loaded value (periodic). Zero is never decremented, so there is no wrap.
module down_counter_tc
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned AUTO_RELOAD = ONE_SHOT
) (
  input logic               clk,
  input logic               reset_n,
  down_counter_tc_if.slave  bus
);

  localparam bit Periodic = (AUTO_RELOAD == PERIODIC);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;

  // State, count, reload value and tc; tc marks any edge that writes zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else if (bus.load) begin
      count_q  <= bus.load_val;
      reload_q <= bus.load_val;
      if (bus.load_val != '0) begin
        state_q <= RUN;
        tc_q    <= 1'b0;
      end else begin
        // Loading zero is an immediate terminal count.
        state_q <= Periodic ? RUN : IDLE;
        tc_q    <= 1'b1;
      end
    end else if (state_q == RUN && bus.en) begin
      if (count_q != '0) begin
        count_q <= count_q - 1'b1;
        tc_q    <= (count_q == WIDTH'(1));
        if (count_q == WIDTH'(1) && !Periodic) begin
          state_q <= IDLE;
        end
      end else begin
        // Only reachable in periodic mode: zero was already signalled.
        count_q <= reload_q;
        tc_q    <= (reload_q == '0);
      end
    end else begin
      tc_q <= 1'b0;
    end
  end

  // Outputs come straight from registers; no input-to-output path.
  assign bus.count_out = count_q;
  assign bus.tc        = tc_q;
  assign bus.busy      = (state_q == RUN);

endmodule

// File: tb/tb_down_counter_tc.sv
// Scoreboard bench: a one-shot and a periodic counter receive identical
// stimulus; a reference model pushes expected outputs per edge and a monitor
// pops and compares them shortly after each rising edge.
module tb_down_counter_tc;

  localparam int unsigned W = 2;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         tc;
    logic         busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  down_counter_tc_if #(.WIDTH(W)) bus0 ();
  down_counter_tc_if #(.WIDTH(W)) bus1 ();

  down_counter_tc #(.WIDTH(W), .AUTO_RELOAD(0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  down_counter_tc #(.WIDTH(W), .AUTO_RELOAD(1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state per instance; index equals AUTO_RELOAD.
  int m_cnt[2];
  int m_rel[2];
  bit m_run[2];
  bit m_tc[2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  // Apply the spec rules with plain integers.
  task automatic model_step(input int i, input bit ld, input int lv, input bit e);
    if (ld) begin
      m_cnt[i] = lv;
      m_rel[i] = lv;
      m_tc[i]  = (lv == 0);
      m_run[i] = (lv != 0) || (i == 1);
    end else if (m_run[i] && e) begin
      if (m_cnt[i] > 0) begin
        m_cnt[i] = m_cnt[i] - 1;
        m_tc[i]  = (m_cnt[i] == 0);
        if (m_cnt[i] == 0 && i == 0) m_run[i] = 1'b0;
      end else begin
        m_cnt[i] = m_rel[i];
        m_tc[i]  = (m_rel[i] == 0);
      end
    end else begin
      m_tc[i] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_rel[i] = 0;
      m_run[i] = 1'b0;
      m_tc[i]  = 1'b0;
    end
  endtask

  task automatic step(input bit ld, input int lv, input bit e);
    exp_t x;
    @(negedge clk);
    bus0.load = ld; bus0.load_val = W'(lv); bus0.en = e;
    bus1.load = ld; bus1.load_val = W'(lv); bus1.en = e;
    for (int i = 0; i < 2; i++) begin
      model_step(i, ld, lv, e);
      x.cnt  = W'(m_cnt[i]);
      x.tc   = m_tc[i];
      x.busy = m_run[i];
      if (i == 0) q0.push_back(x);
      else        q1.push_back(x);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, " dut0 count"}, 32'(bus0.count_out), 0);
    chk({tag, " dut0 tc"},    32'(bus0.tc), 0);
    chk({tag, " dut0 busy"},  32'(bus0.busy), 0);
    chk({tag, " dut1 count"}, 32'(bus1.count_out), 0);
    chk({tag, " dut1 tc"},    32'(bus1.tc), 0);
    chk({tag, " dut1 busy"},  32'(bus1.busy), 0);
  endtask

  // Asynchronous reset asserted between edges, checked before any clock.
  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_zero_outputs("async reset");
    model_reset();
    bus0.load = 1'b0; bus0.en = 1'b0; bus0.load_val = '0;
    bus1.load = 1'b0; bus1.en = 1'b0; bus1.load_val = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: outputs are valid every cycle once an expectation is queued.
  always begin
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("dut0 count", 32'(bus0.count_out), 32'(e.cnt));
      chk("dut0 tc",    32'(bus0.tc),        32'(e.tc));
      chk("dut0 busy",  32'(bus0.busy),      32'(e.busy));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("dut1 count", 32'(bus1.count_out), 32'(e.cnt));
      chk("dut1 tc",    32'(bus1.tc),        32'(e.tc));
      chk("dut1 busy",  32'(bus1.busy),      32'(e.busy));
    end
  end

  initial begin
    bus0.load = 1'b0; bus0.load_val = '0; bus0.en = 1'b0;
    bus1.load = 1'b0; bus1.load_val = '0; bus1.en = 1'b0;
    model_reset();
    #12 check_zero_outputs("power-on reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Count from 3 with en held: one-shot stops at 0, periodic wraps to 3.
    step(1'b1, 3, 1'b1);
    repeat (6) step(1'b0, 0, 1'b1);

    // Periodic load 2.
    step(1'b1, 2, 1'b1);
    repeat (7) step(1'b0, 0, 1'b1);

    // Enable gating.
    step(1'b1, 3, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);

    // Load wins over en on the same edge.
    step(1'b1, 3, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b1, 2, 1'b1);
    step(1'b0, 0, 1'b1);

    // Load zero.
    step(1'b1, 0, 1'b1);
    repeat (4) step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);

    // Reset mid-count after two edges.
    step(1'b1, 3, 1'b1);
    step(1'b0, 0, 1'b1);
    do_reset();

    // Randomised traffic with one extra mid-run reset.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0));
      if (k == 200) do_reset();
    end

    repeat (2) step(1'b0, 0, 1'b0);
    @(negedge clk);
    chk("scoreboard drained dut0", 32'(q0.size()), 0);
    chk("scoreboard drained dut1", 32'(q1.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
